evt_sched: RTL and testbench
============================

EVT_SCHED -- requirements
Module: evt_sched

Interface
REQ-001 Parameter NBA_DEPTH, 4, depth of the nonblocking-update FIFO; SHALL be a power of two, at least 2.
REQ-002 Parameter TW, 16, width of the monitor timestamp.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester write request; the requester holds it, with its fields stable, until granted.
REQ-006 req_nba  input  3  per-requester flag: 1 = nonblocking (deferred) write, 0 = blocking (immediate) write.
REQ-007 req_addr  input  6  2-bit register address per requester; requester i uses bits [2i+1:2i].
REQ-008 req_data  input  6  2-bit write data per requester, packed the same way as req_addr.
REQ-009 gnt  output  3  one-hot grant, combinational; the request is accepted in the cycle gnt is high.
REQ-010 regs  output  8  four 2-bit registers; register k occupies bits [2k+1:2k].
REQ-011 nba_count  output  $clog2(NBA_DEPTH)+1  number of FIFO entries.
REQ-012 nba_full  output  1  high when nba_count equals NBA_DEPTH.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 mon_valid  output  1  one-cycle strobe that reports a change in regs.
REQ-015 mon_time  output  TW  cycle timestamp of the change reported by mon_valid.

Function
REQ-016 A request is eligible when req[i]=1 and either req_nba[i]=0, or req_nba[i]=1 and nba_full=0.
REQ-017 States:
- IDLE: no activity.
- ACTIVE: grants requests.
- NBA: drains the FIFO.
REQ-018 In ACTIVE, the block SHALL grant at most one eligible request per cycle using round-robin arbitration.
- After a grant to requester i, priority order starts at (i+1) mod 3.
- After reset, requester 0 has highest priority.
REQ-019 In IDLE, an eligible request SHALL move the state to ACTIVE and SHALL be granted in the same cycle.
REQ-020 A granted blocking write SHALL appear in regs on the next cycle.
REQ-021 A granted nonblocking write SHALL push {addr,data} into the FIFO; regs SHALL be unchanged.
REQ-022 ACTIVE to NBA: when no request is eligible and nba_count is greater than 0, the state SHALL move to NBA.
- This includes the case where only nonblocking requests blocked by a full FIFO are pending.
REQ-023 In NBA, the block SHALL pop one entry per cycle in FIFO order and apply it to regs on the next cycle.
- No grants SHALL be issued in NBA.
REQ-024 On the final pop, the state SHALL move to ACTIVE if any req is high, otherwise to IDLE.
REQ-025 ACTIVE to IDLE: when no req is high and the FIFO is empty, the state SHALL move to IDLE.
REQ-026 Blocking writes and FIFO pops are mutually exclusive per cycle; a push and a pop SHALL never occur in the same cycle.
REQ-027 Later writes to the same address SHALL overwrite earlier ones in the order applied.
- A deferred write therefore overrides a blocking write granted before the drain.
REQ-028 The FIFO read and write pointers SHALL wrap modulo NBA_DEPTH; overflow and underflow are impossible by construction.

Reset
REQ-029 While reset=1 the block SHALL drive:
- regs=0, nba_count=0, nba_full=0, busy=0, gnt=0;
- state IDLE, round-robin pointer at requester 0;
- mon_valid=0, mon_time=0, timestamp counter=0.
REQ-030 Reset during ACTIVE or NBA SHALL discard all FIFO contents; discarded entries SHALL never reach regs.

Configuration
REQ-031 When the macro EVT_SCHED_MONITOR_EN is defined:
- A TW-bit cycle counter SHALL increment every non-reset cycle and wrap at its maximum.
- mon_valid SHALL pulse in the cycle after regs changes value.
- mon_time SHALL hold the counter value of the cycle in which regs changed.
REQ-032 When EVT_SCHED_MONITOR_EN is undefined, the counter SHALL be absent and mon_valid and mon_time SHALL be tied to 0.

Verification
REQ-033 Reset: assert reset for 2 cycles -> regs=8'h00, gnt=0, busy=0, nba_count=0.
REQ-034 Single blocking write:
- Stimulus: req=001, req_nba=0, addr0=1, data0=3.
- Response: gnt=001 in the same cycle; regs=8'h0C on the next cycle.
- With the monitor compiled in: one mon_valid pulse.
REQ-035 Round-robin:
- Stimulus: all three blocking requests held continuously.
- Response: gnt sequence 001, 010, 100, 001.
REQ-036 Ordering:
- Stimulus: requester 0 issues nonblocking reg2=1, then blocking reg2=2.
- Response: regs[5:4]=2, then 1 after the NBA drain; the final value is 1.
REQ-037 Full FIFO:
- Stimulus: five nonblocking requests.
- Response: four accepted and nba_full=1; the fifth is held; the state goes to NBA.
- Entries drain over 4 cycles in order, then the fifth is granted.
REQ-038 Reset mid-drain:
- Stimulus: nba_count=3 in NBA state, assert reset.
- Response: nba_count=0 and regs=0 on the next cycle; no discarded entry is ever applied.

Source files
------------

// File: rtl/evt_sched.sv
// evt_sched: three-requester register-write scheduler with round-robin grants and a deferred-write (NBA) FIFO.
// Optional cycle-stamped change monitor is compiled in when EVT_SCHED_MONITOR_EN is defined.

module evt_sched #(
  parameter int NBA_DEPTH = 4,
  parameter int TW        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 req,
  input  logic [2:0]                 req_nba,
  input  logic [5:0]                 req_addr,
  input  logic [5:0]                 req_data,
  output logic [2:0]                 gnt,
  output logic [7:0]                 regs,
  output logic [$clog2(NBA_DEPTH):0] nba_count,
  output logic                       nba_full,
  output logic                       busy,
  output logic                       mon_valid,
  output logic [TW-1:0]              mon_time
);

  localparam int PW = $clog2(NBA_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, NBA} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rr_q;
  logic [7:0]    regs_q, regs_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    fifo_q [NBA_DEPTH];
  logic          busy_q;

  logic [3:0]    elig;
  logic          found;
  logic [1:0]    gidx, cand;
  logic [1:0]    sel_addr, sel_data;
  logic          sel_nba;
  logic          push, pop;
  logic [3:0]    head;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign nba_full  = (count_q == CW'(NBA_DEPTH));
  assign nba_count = count_q;
  assign regs      = regs_q;
  assign busy      = busy_q;
  assign head      = fifo_q[rd_ptr_q];

  // Round-robin search starting at rr_q; a full FIFO masks nonblocking requesters.
  always_comb begin
    elig  = {1'b0, req & ~(req_nba & {3{nba_full}})};
    found = 1'b0;
    gidx  = 2'd0;
    cand  = 2'd0;
    if (!reset && state_q != NBA) begin
      for (int k = 0; k < 3; k++) begin
        cand = wrap3({1'b0, rr_q} + 3'(k));
        if (!found && elig[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
      end
    end
    gnt = found ? 3'(3'b001 << gidx) : 3'b000;
    case (gidx)
      2'd1:    begin sel_addr = req_addr[3:2]; sel_data = req_data[3:2]; sel_nba = req_nba[1]; end
      2'd2:    begin sel_addr = req_addr[5:4]; sel_data = req_data[5:4]; sel_nba = req_nba[2]; end
      default: begin sel_addr = req_addr[1:0]; sel_data = req_data[1:0]; sel_nba = req_nba[0]; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    push    = found & sel_nba;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (found) state_d = ACTIVE;
      ACTIVE: begin
        if (!found) begin
          if (count_q != '0)       state_d = NBA;
          else if (req == 3'b000)  state_d = IDLE;
        end
      end
      NBA: begin
        pop = (count_q != '0);
        if (count_q <= CW'(1)) state_d = (req != 3'b000) ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Grants never occur in NBA, so a blocking write and a pop cannot collide.
    for (int k = 0; k < 4; k++) begin
      if (found && !sel_nba && sel_addr == 2'(k)) regs_d[2*k +: 2] = sel_data;
      if (pop && head[3:2] == 2'(k))              regs_d[2*k +: 2] = head[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 2'd0;
      regs_q   <= 8'h00;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      regs_q  <= regs_d;
      if (found) rr_q <= wrap3({1'b0, gidx} + 3'd1);
      if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push)      count_q <= count_q + CW'(1);
      else if (pop)  count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: a reset rewinds the pointers, which discards any queued entries.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {sel_addr, sel_data};
  end

`ifdef EVT_SCHED_MONITOR_EN
  logic [TW-1:0] cyc_q, time_q;
  logic [7:0]    prev_q;
  logic          valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      time_q  <= '0;
      prev_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      cyc_q   <= cyc_q + TW'(1);
      prev_q  <= regs_q;
      valid_q <= (regs_q != prev_q);
      if (regs_q != prev_q) time_q <= cyc_q;
    end
  end

  assign mon_valid = valid_q;
  assign mon_time  = time_q;
`else
  assign mon_valid = 1'b0;
  assign mon_time  = '0;
`endif

endmodule

// File: tb/tb_evt_sched.sv
// Self-checking bench for evt_sched: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.

module tb_evt_sched;

  localparam int DEPTH = 4;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req, req_nba;
  logic [5:0]    req_addr, req_data;
  logic [2:0]    gnt;
  logic [7:0]    regs;
  logic [2:0]    nba_count;
  logic          nba_full, busy, mon_valid;
  logic [TW-1:0] mon_time;

  evt_sched #(.NBA_DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_nba(req_nba),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .regs(regs),
    .nba_count(nba_count), .nba_full(nba_full), .busy(busy),
    .mon_valid(mon_valid), .mon_time(mon_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  // Behavioural model: mode 0 = idle, 1 = granting, 2 = draining the deferred queue.
  int            mMode;
  int            mRr;
  logic [1:0]    mRegs [4];
  logic [3:0]    mQ [$];
  logic [2:0]    mGntLast;
  logic [TW-1:0] mCyc, mMonT;
  logic          mMonV;
  logic [7:0]    mSeen;

  logic [2:0] rrExp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         dSeq  [4] = '{1, 2, 3, 2};

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] packRegs();
    return {mRegs[3], mRegs[2], mRegs[1], mRegs[0]};
  endfunction

  function automatic logic [2:0] modelGrant();
    bit full;
    int i;
    full = (mQ.size() == DEPTH);
    if (reset || mMode == 2) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      i = (mRr + k) % 3;
      if (req[i] && (!req_nba[i] || !full)) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  task automatic resetModel();
    mMode = 0;
    mRr   = 0;
    for (int k = 0; k < 4; k++) mRegs[k] = 2'd0;
    mQ.delete();
    mCyc  = '0;
    mMonT = '0;
    mMonV = 1'b0;
    mSeen = 8'h00;
    mGntLast = 3'b000;
  endtask

  task automatic checkOutput();
    checkVal("gnt", {29'd0, gnt}, {29'd0, modelGrant()});
    checkVal("regs", {24'd0, regs}, {24'd0, packRegs()});
    checkVal("nba_count", {29'd0, nba_count}, mQ.size());
    checkVal("nba_full", {31'd0, nba_full}, (mQ.size() == DEPTH) ? 1 : 0);
    checkVal("busy", {31'd0, busy}, (mMode != 0) ? 1 : 0);
`ifdef EVT_SCHED_MONITOR_EN
    checkVal("mon_valid", {31'd0, mon_valid}, {31'd0, mMonV});
    checkVal("mon_time", {16'd0, mon_time}, {16'd0, mMonT});
`else
    checkVal("mon_valid", {31'd0, mon_valid}, 0);
    checkVal("mon_time", {16'd0, mon_time}, 0);
`endif
  endtask

  task automatic modelStep();
    logic [2:0] g;
    logic [7:0] cur;
    logic [3:0] e;
    logic [5:0] a, d;
    int         i;
    g   = modelGrant();
    cur = packRegs();
    if (reset) begin
      resetModel();
      return;
    end
    mGntLast = g;
    mMonV = (cur != mSeen);
    if (mMonV) mMonT = mCyc;
    mSeen = cur;
    mCyc  = mCyc + 1'b1;
    if (mMode == 2) begin
      e = mQ.pop_front();
      mRegs[e[3:2]] = e[1:0];
      if (mQ.size() == 0) mMode = (req != 3'b000) ? 1 : 0;
    end else if (g != 3'b000) begin
      i = g[0] ? 0 : (g[1] ? 1 : 2);
      mRr   = (i + 1) % 3;
      mMode = 1;
      a = req_addr >> (2 * i);
      d = req_data >> (2 * i);
      if (req_nba[i]) mQ.push_back({a[1:0], d[1:0]});
      else            mRegs[a[1:0]] = d[1:0];
    end else if (mMode == 1) begin
      if (mQ.size() > 0)        mMode = 2;
      else if (req == 3'b000)   mMode = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [2:0] nb,
                               input logic [5:0] ad, input logic [5:0] da);
    reset    = r;
    req      = rq;
    req_nba  = nb;
    req_addr = ad;
    req_data = da;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wait (chkEn);
    forever begin
      @(negedge clk);
      checkOutput();
      modelStep();
    end
  end

  initial begin
    bit         pend [3];
    logic       pnba [3];
    logic [1:0] pa [3], pd [3];
    logic [2:0] rq, nb;
    logic [5:0] ad, da;
    logic [7:0] snap;

    resetModel();
    applyStimulus(1'b1, 3'b000, 3'b000, 6'd0, 6'd0);
    @(posedge clk);
    #1 chkEn = 1'b1;
    cyc();
    @(negedge clk);
    checkVal("rst_regs", {24'd0, regs}, 32'h00);
    checkVal("rst_gnt", {29'd0, gnt}, 0);
    checkVal("rst_busy", {31'd0, busy}, 0);
    checkVal("rst_count", {29'd0, nba_count}, 0);

    // Single blocking write to register 1.
    cyc();
    applyStimulus(1'b0, 3'b001, 3'b000, 6'b000001, 6'b000011);
    @(negedge clk);
    checkVal("blk_gnt", {29'd0, gnt}, 32'b001);
    cyc();
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    @(negedge clk);
    checkVal("blk_regs", {24'd0, regs}, 32'h0C);
    cyc();
    @(negedge clk);
`ifdef EVT_SCHED_MONITOR_EN
    checkVal("blk_mon_valid", {31'd0, mon_valid}, 1);
    checkVal("blk_mon_time", {16'd0, mon_time}, 1);
`else
    checkVal("blk_mon_valid", {31'd0, mon_valid}, 0);
`endif
    repeat (3) cyc();

    // Round-robin with all three blocking requests held.
    applyStimulus(1'b1, 3'b000, 3'b000, 6'd0, 6'd0);
    cyc();
    applyStimulus(1'b0, 3'b111, 3'b000, 6'd0, 6'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkVal($sformatf("rr_gnt%0d", k), {29'd0, gnt}, {29'd0, rrExp[k]});
      cyc();
    end
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    repeat (3) cyc();

    // Deferred write to reg2 followed by a blocking write to the same register.
    applyStimulus(1'b0, 3'b001, 3'b001, 6'd2, 6'd1);
    @(negedge clk);
    checkVal("ord_gnt_nb", {29'd0, gnt}, 32'b001);
    cyc();
    applyStimulus(1'b0, 3'b001, 3'b000, 6'd2, 6'd2);
    @(negedge clk);
    checkVal("ord_gnt_blk", {29'd0, gnt}, 32'b001);
    cyc();
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    @(negedge clk);
    snap = regs;
    checkVal("ord_reg2_blk", {30'd0, snap[5:4]}, 2);
    cyc();
    @(negedge clk);
    snap = regs;
    checkVal("ord_reg2_popcyc", {30'd0, snap[5:4]}, 2);
    cyc();
    @(negedge clk);
    snap = regs;
    checkVal("ord_reg2_final", {30'd0, snap[5:4]}, 1);
    repeat (2) cyc();

    // Five deferred writes: four fill the FIFO, the fifth waits for the drain.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 3'b001, 3'b001, 6'd3, 6'(dSeq[k]));
      @(negedge clk);
      checkVal($sformatf("full_gnt%0d", k), {29'd0, gnt}, 32'b001);
      cyc();
    end
    applyStimulus(1'b0, 3'b001, 3'b001, 6'd0, 6'd3);
    @(negedge clk);
    checkVal("full_held_gnt", {29'd0, gnt}, 0);
    checkVal("full_flag", {31'd0, nba_full}, 1);
    checkVal("full_count", {29'd0, nba_count}, 4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      checkVal($sformatf("drain_gnt%0d", k), {29'd0, gnt}, 0);
      if (k >= 1) begin
        snap = regs;
        checkVal($sformatf("drain_reg3_%0d", k), {30'd0, snap[7:6]}, dSeq[k-1]);
      end
    end
    cyc();
    @(negedge clk);
    snap = regs;
    checkVal("fifth_gnt", {29'd0, gnt}, 32'b001);
    checkVal("drain_reg3_last", {30'd0, snap[7:6]}, dSeq[3]);
    cyc();
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    repeat (3) cyc();
    @(negedge clk);
    snap = regs;
    checkVal("fifth_reg0", {30'd0, snap[1:0]}, 3);

    // Reset while draining three queued entries.
    cyc();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'b001, 3'b001, 6'(k + 1), 6'(3 - k));
      cyc();
    end
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    cyc();
    applyStimulus(1'b1, 3'b000, 3'b000, 6'd0, 6'd0);
    @(negedge clk);
    checkVal("mid_count_pre", {29'd0, nba_count}, 3);
    cyc();
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    @(negedge clk);
    checkVal("mid_count_post", {29'd0, nba_count}, 0);
    checkVal("mid_regs_post", {24'd0, regs}, 0);
    repeat (5) cyc();
    @(negedge clk);
    checkVal("mid_regs_later", {24'd0, regs}, 0);

    // Randomized traffic; requesters hold fields until the model reports their grant.
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rq = 3'b000; nb = 3'b000; ad = 6'd0; da = 6'd0;
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && mGntLast[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          pnba[i] = ($urandom_range(0, 99) < 60);
          pa[i]   = 2'($urandom_range(0, 3));
          pd[i]   = 2'($urandom_range(0, 3));
        end
        rq[i] = pend[i];
        nb[i] = pend[i] ? pnba[i] : 1'b0;
        ad[2*i +: 2] = pend[i] ? pa[i] : 2'd0;
        da[2*i +: 2] = pend[i] ? pd[i] : 2'd0;
      end
      applyStimulus(($urandom_range(0, 249) == 0), rq, nb, ad, da);
    end

    cyc();
    applyStimulus(1'b0, 3'b000, 3'b000, 6'd0, 6'd0);
    repeat (8) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
